calc_ctrl: RTL and testbench
============================

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port key, input, 4 bits: decoded key code from the shared key-code package.
REQ-004 SHALL have port key_valid, input, 1 bit: one-cycle strobe marking a new press on key.
REQ-005 SHALL have port disp_mag, output, 14 bits: unsigned magnitude to display.
REQ-006 SHALL have port disp_neg, output, 1 bit: display value is negative.
REQ-007 SHALL have port busy, output, 1 bit: high while state is CALC.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse on entry to RESULT.
REQ-009 SHALL have port state_o, output, 2 bits: current FSM state, for debug.

Function
REQ-010 SHALL implement an FSM with states OPA=0, OPB=1, CALC=2, RESULT=3; a press is a rising edge of clk with key_valid=1.
REQ-011 SHALL ignore presses of any code not defined in the package.
REQ-012 In OPA or OPB, a digit press SHALL set operand = operand*10 + digit while the digit count is below 2; a third digit SHALL be ignored.
REQ-013 In OPA, an ADD/SUBTRACT/MULTIPLY press SHALL latch op and enter OPB with operand b=0; with zero digits entered, a=0.
REQ-014 In OPB with zero b digits, an operator press SHALL replace op; with one or more b digits it SHALL be ignored.
REQ-015 ENTER SHALL be ignored in OPA, and in OPB with zero b digits.
REQ-016 In OPB with one or more b digits, ENTER SHALL enter CALC.
REQ-017 CALC SHALL last exactly 1 cycle for ADD/SUBTRACT and exactly 7 cycles for MULTIPLY (shift-add, one multiplier bit per cycle).
REQ-018 Presses during CALC SHALL be dropped, not queued.
REQ-019 ADD SHALL produce a+b (0..198); SUBTRACT SHALL produce |a-b| with the sign flag set when a<b; MULTIPLY SHALL produce a*b (0..9801, 14 bits).
REQ-020 CALC SHALL exit to RESULT, registering the result and pulsing done for that one cycle.
REQ-021 In RESULT, a digit press SHALL clear everything, set a=digit with one digit counted, and enter OPA.
REQ-022 In RESULT, ENTER SHALL clear to the reset state.
REQ-023 In RESULT, operator presses SHALL be ignored.
REQ-024 disp_mag SHALL equal a in OPA; b in OPB, or a while b has zero digits; a in CALC; the result in RESULT.
REQ-025 disp_neg SHALL be 1 only in RESULT after a negative subtraction.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 When rst=1 at a clk edge: state=OPA, a=b=0, digit counts=0, op=ADD, result=0, disp_mag=0, disp_neg=0, busy=0, done=0.
REQ-028 Reset SHALL take priority over any press and SHALL abort an in-progress CALC, with no done pulse.

Structure
REQ-029 The shared key-code package SHALL hold KEY_0..KEY_9=4'd0..4'd9, KEY_ADD=4'd10, KEY_SUBTRACT=4'd11, KEY_MULTIPLY=4'd12, KEY_ENTER=4'd13, and the FSM state encodings.
REQ-030 The multiplier SHALL be a sub-module seq_mult with start/done handshake, 7-bit operands, 14-bit product, and the same clk/rst.

Verification
REQ-031 Keys 1,2,ADD,3,4,ENTER -> busy for 1 cycle, then done pulse, disp_mag=46, disp_neg=0.
REQ-032 Keys 5,SUBTRACT,7,8,ENTER -> disp_mag=73, disp_neg=1.
REQ-033 Keys 9,9,MULTIPLY,9,9,ENTER -> busy exactly 7 cycles, then disp_mag=9801, done 1 cycle.
REQ-034 Keys 1,2,3 -> disp_mag=12; ENTER in OPA -> no state change.
REQ-035 Key 4 pressed during a multiply CALC -> dropped; result unaffected.
REQ-036 rst asserted in CALC cycle 3 -> next cycle state=OPA, all outputs 0, no done pulse.

Source files
------------

// File: rtl/calc_ctrl_pkg.sv
// calc_ctrl_pkg: shared key codes, FSM state encodings, operator type and
// small decode helpers for the two-operand keypad calculator.
// No ports (package).
package calc_ctrl_pkg;

  localparam logic [3:0] KEY_0        = 4'd0;
  localparam logic [3:0] KEY_1        = 4'd1;
  localparam logic [3:0] KEY_2        = 4'd2;
  localparam logic [3:0] KEY_3        = 4'd3;
  localparam logic [3:0] KEY_4        = 4'd4;
  localparam logic [3:0] KEY_5        = 4'd5;
  localparam logic [3:0] KEY_6        = 4'd6;
  localparam logic [3:0] KEY_7        = 4'd7;
  localparam logic [3:0] KEY_8        = 4'd8;
  localparam logic [3:0] KEY_9        = 4'd9;
  localparam logic [3:0] KEY_ADD      = 4'd10;
  localparam logic [3:0] KEY_SUBTRACT = 4'd11;
  localparam logic [3:0] KEY_MULTIPLY = 4'd12;
  localparam logic [3:0] KEY_ENTER    = 4'd13;

  localparam int OPND_W = 7;
  localparam int PROD_W = 14;

  localparam logic [1:0] MAX_DIGITS = 2'd2;

  typedef enum logic [1:0] {
    ST_OPA    = 2'd0,
    ST_OPB    = 2'd1,
    ST_CALC   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k >= KEY_0) && (k <= KEY_9);
  endfunction

  function automatic logic is_operator(input logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUBTRACT) || (k == KEY_MULTIPLY);
  endfunction

  function automatic op_t key_to_op(input logic [3:0] k);
    case (k)
      KEY_SUBTRACT: return OP_SUB;
      KEY_MULTIPLY: return OP_MUL;
      default:      return OP_ADD;
    endcase
  endfunction

  // Operand is capped at two digits, so v*10+d never exceeds 99.
  function automatic logic [OPND_W-1:0] shift_in_digit(input logic [OPND_W-1:0] v,
                                                       input logic [3:0] d);
    return (v * 7'd10) + {3'b000, d};
  endfunction

endpackage

// File: rtl/calc_ctrl_seq_mult.sv
// seq_mult: 7x7 unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               load operands (bit 0 is consumed on the load edge)
//   mcand_in, mplier_in 7-bit operands
//   product             14-bit product, valid when done pulses and held after
//   done                one-cycle pulse after the 7th bit has been consumed
module seq_mult
  import calc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OPND_W-1:0] mcand_in,
  input  logic [OPND_W-1:0] mplier_in,
  output logic [PROD_W-1:0] product,
  output logic              done
);

  logic [PROD_W-1:0] mcand_sh;
  logic [OPND_W-1:0] mplier_sh;
  logic [2:0]        steps_left;
  logic              running;

  always_ff @(posedge clk) begin
    if (rst) begin
      product    <= '0;
      mcand_sh   <= '0;
      mplier_sh  <= '0;
      steps_left <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else if (start) begin
      // The load edge also accumulates bit 0, so the remaining six bits
      // finish in time for a seven-cycle busy window upstream.
      product    <= mplier_in[0] ? {7'b0, mcand_in} : '0;
      mcand_sh   <= {6'b0, mcand_in, 1'b0};
      mplier_sh  <= {1'b0, mplier_in[OPND_W-1:1]};
      steps_left <= 3'd6;
      running    <= 1'b1;
      done       <= 1'b0;
    end else if (running) begin
      if (mplier_sh[0]) begin
        product <= product + mcand_sh;
      end
      mcand_sh   <= mcand_sh << 1;
      mplier_sh  <= mplier_sh >> 1;
      steps_left <= steps_left - 3'd1;
      if (steps_left == 3'd1) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad calculator controller. Collects two 2-digit operands and an
// operator, runs add/subtract in one cycle or multiply through seq_mult, and
// presents the value to display.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   key        4-bit key code (see calc_ctrl_pkg)
//   key_valid  one-cycle strobe marking a press
//   disp_mag   14-bit magnitude to display
//   disp_neg   displayed value is negative
//   busy       high while calculating
//   done       one-cycle pulse on entry to RESULT
//   state_o    current FSM state
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_OPA    | entering operand a
// ST_OPB    | operator latched, entering operand b
// ST_CALC   | computing; presses dropped
// ST_RESULT | result shown; digit starts over, ENTER clears
module calc_ctrl
  import calc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  input  logic        key_valid,
  output logic [13:0] disp_mag,
  output logic        disp_neg,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_o
);

  state_t            state, state_n;
  op_t               op, op_n;
  logic [OPND_W-1:0] a, a_n, b, b_n;
  logic [1:0]        a_cnt, a_cnt_n, b_cnt, b_cnt_n;
  logic [PROD_W-1:0] result, result_n;
  logic              res_neg, res_neg_n;
  logic [PROD_W-1:0] disp_mag_n;
  logic              mult_start;
  logic [PROD_W-1:0] mult_product;
  logic              mult_done;

  seq_mult u_mult (
    .clk       (clk),
    .rst       (rst),
    .start     (mult_start),
    .mcand_in  (a),
    .mplier_in (b),
    .product   (mult_product),
    .done      (mult_done)
  );

  always_comb begin
    state_n    = state;
    op_n       = op;
    a_n        = a;
    b_n        = b;
    a_cnt_n    = a_cnt;
    b_cnt_n    = b_cnt;
    result_n   = result;
    res_neg_n  = res_neg;
    mult_start = 1'b0;

    case (state)
      ST_OPA: begin
        if (key_valid) begin
          if (is_digit(key)) begin
            if (a_cnt < MAX_DIGITS) begin
              a_n     = shift_in_digit(a, key);
              a_cnt_n = a_cnt + 2'd1;
            end
          end else if (is_operator(key)) begin
            op_n    = key_to_op(key);
            b_n     = '0;
            b_cnt_n = '0;
            state_n = ST_OPB;
          end
        end
      end

      ST_OPB: begin
        if (key_valid) begin
          if (is_digit(key)) begin
            if (b_cnt < MAX_DIGITS) begin
              b_n     = shift_in_digit(b, key);
              b_cnt_n = b_cnt + 2'd1;
            end
          end else if (is_operator(key)) begin
            if (b_cnt == 2'd0) begin
              op_n = key_to_op(key);
            end
          end else if (key == KEY_ENTER) begin
            if (b_cnt != 2'd0) begin
              state_n    = ST_CALC;
              mult_start = (op == OP_MUL);
            end
          end
        end
      end

      ST_CALC: begin
        case (op)
          OP_SUB: begin
            result_n  = (a >= b) ? {7'b0, a - b} : {7'b0, b - a};
            res_neg_n = (a < b);
            state_n   = ST_RESULT;
          end
          OP_MUL: begin
            if (mult_done) begin
              result_n  = mult_product;
              res_neg_n = 1'b0;
              state_n   = ST_RESULT;
            end
          end
          default: begin
            result_n  = {7'b0, a} + {7'b0, b};
            res_neg_n = 1'b0;
            state_n   = ST_RESULT;
          end
        endcase
      end

      ST_RESULT: begin
        if (key_valid) begin
          if (is_digit(key)) begin
            a_n       = {3'b000, key};
            a_cnt_n   = 2'd1;
            b_n       = '0;
            b_cnt_n   = '0;
            op_n      = OP_ADD;
            result_n  = '0;
            res_neg_n = 1'b0;
            state_n   = ST_OPA;
          end else if (key == KEY_ENTER) begin
            a_n       = '0;
            a_cnt_n   = '0;
            b_n       = '0;
            b_cnt_n   = '0;
            op_n      = OP_ADD;
            result_n  = '0;
            res_neg_n = 1'b0;
            state_n   = ST_OPA;
          end
        end
      end

      default: state_n = ST_OPA;
    endcase

    case (state_n)
      ST_OPB:    disp_mag_n = (b_cnt_n == 2'd0) ? {7'b0, a_n} : {7'b0, b_n};
      ST_RESULT: disp_mag_n = result_n;
      default:   disp_mag_n = {7'b0, a_n};
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_OPA;
      op       <= OP_ADD;
      a        <= '0;
      b        <= '0;
      a_cnt    <= '0;
      b_cnt    <= '0;
      result   <= '0;
      res_neg  <= 1'b0;
      disp_mag <= '0;
      disp_neg <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      op       <= op_n;
      a        <= a_n;
      b        <= b_n;
      a_cnt    <= a_cnt_n;
      b_cnt    <= b_cnt_n;
      result   <= result_n;
      res_neg  <= res_neg_n;
      disp_mag <= disp_mag_n;
      disp_neg <= (state_n == ST_RESULT) && res_neg_n;
      busy     <= (state_n == ST_CALC);
      done     <= (state == ST_CALC) && (state_n == ST_RESULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_ENT = 4'd13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key = 4'd0;
  logic        key_valid = 1'b0;
  logic [13:0] disp_mag;
  logic        disp_neg;
  logic        busy;
  logic        done;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: 0=OPA 1=OPB 2=CALC 3=RESULT, plain integers.
  int m_st, ma, mb, mac, mbc, mop, mres, mneg, mleft, mdone;

  calc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_valid (key_valid),
    .disp_mag  (disp_mag),
    .disp_neg  (disp_neg),
    .busy      (busy),
    .done      (done),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; ma = 0; mb = 0; mac = 0; mbc = 0;
    mop = 10; mres = 0; mneg = 0; mleft = 0;
  endtask

  task automatic model_clk(input bit r, input int k, input bit v);
    mdone = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (m_st == 2) begin
      mleft--;
      if (mleft == 0) begin
        m_st  = 3;
        mdone = 1;
        if (mop == 11) begin
          mres = (ma >= mb) ? ma - mb : mb - ma;
          mneg = (ma < mb) ? 1 : 0;
        end else if (mop == 12) begin
          mres = ma * mb;
          mneg = 0;
        end else begin
          mres = ma + mb;
          mneg = 0;
        end
      end
      return;
    end
    if (!v || k > 13) return;
    if (m_st == 0 || m_st == 1) begin
      if (k <= 9) begin
        if (m_st == 0 && mac < 2) begin ma = ma * 10 + k; mac++; end
        if (m_st == 1 && mbc < 2) begin mb = mb * 10 + k; mbc++; end
      end else if (k <= 12) begin
        if (m_st == 0) begin
          mop = k; mb = 0; mbc = 0; m_st = 1;
        end else if (mbc == 0) begin
          mop = k;
        end
      end else if (m_st == 1 && mbc > 0) begin
        m_st  = 2;
        mleft = (mop == 12) ? 7 : 1;
      end
    end else if (m_st == 3) begin
      if (k <= 9) begin
        model_reset();
        ma = k; mac = 1;
      end else if (k == 13) begin
        model_reset();
      end
    end
  endtask

  task automatic cyc(input bit r, input logic [3:0] k, input bit v);
    int exp_mag;
    rst = r; key = k; key_valid = v;
    @(posedge clk);
    model_clk(r, int'(k), v);
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0;
    case (m_st)
      1:       exp_mag = (mbc == 0) ? ma : mb;
      3:       exp_mag = mres;
      default: exp_mag = ma;
    endcase
    chk("state_o",  state_o,  m_st);
    chk("disp_mag", disp_mag, exp_mag);
    chk("disp_neg", disp_neg, (m_st == 3) ? mneg : 0);
    chk("busy",     busy,     (m_st == 2) ? 1 : 0);
    chk("done",     done,     mdone);
  endtask

  task automatic press(input logic [3:0] k);
    cyc(1'b0, k, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    int nb, nd;
    model_reset();

    // Reset state
    cyc(1'b1, 4'd0, 1'b0);
    cyc(1'b1, K_ENT, 1'b1);
    chk("rst_state", state_o, 0);
    chk("rst_mag", disp_mag, 0);

    // 12 + 34
    press(4'd1); press(4'd2); press(K_ADD); press(4'd3); press(4'd4); press(K_ENT);
    chk("add_busy", busy, 1);
    idle();
    chk("add_done", done, 1);
    chk("add_mag", disp_mag, 46);
    chk("add_neg", disp_neg, 0);
    idle();
    chk("add_done_once", done, 0);

    // 5 - 78
    press(K_ENT);
    press(4'd5); press(K_SUB); press(4'd7); press(4'd8); press(K_ENT);
    idle();
    chk("sub_mag", disp_mag, 73);
    chk("sub_neg", disp_neg, 1);

    // 99 * 99, busy window length
    press(K_ENT);
    press(4'd9); press(4'd9); press(K_MUL); press(4'd9); press(4'd9); press(K_ENT);
    nb = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      nb += int'(busy);
      nd += int'(done);
      idle();
    end
    chk("mul_busy_cycles", nb, 7);
    chk("mul_done_pulses", nd, 1);
    chk("mul_mag", disp_mag, 9801);

    // third digit ignored, ENTER in OPA ignored
    press(K_ENT);
    press(4'd1); press(4'd2); press(4'd3);
    chk("three_digit_mag", disp_mag, 12);
    press(K_ENT);
    chk("enter_opa_state", state_o, 0);

    // press during multiply is dropped: 12 * 5
    press(K_MUL); press(4'd5); press(K_ENT);
    idle();
    press(4'd4);
    for (int i = 0; i < 6; i++) idle();
    chk("drop_state", state_o, 3);
    chk("drop_mag", disp_mag, 60);

    // reset during CALC cycle 3
    press(K_ENT);
    press(4'd3); press(K_MUL); press(4'd4); press(K_ENT);
    idle();
    idle();
    cyc(1'b1, 4'd0, 1'b0);
    chk("abort_state", state_o, 0);
    chk("abort_mag", disp_mag, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      nd += int'(done);
    end
    chk("abort_no_done", nd, 0);

    // randomized presses against the model
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rk;
      bit rr, rv;
      rr = ($urandom_range(0, 79) == 0);
      rv = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) rk = 4'($urandom_range(0, 9));
      else                           rk = 4'($urandom_range(0, 15));
      cyc(rr, rk, rv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
